// File: rtl/dma_chan_scheduler.sv
// Per-channel descriptor queues feeding one DMA engine through a round-robin scheduler.
// Latency: a push is issued on dma_go_o two cycles after it is captured; 3 idle cycles between transfers.
// Backpressure: ch_ready_o drops while a queue holds QUEUE_DEPTH entries (in-flight entry included).
module dma_chan_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int QUEUE_DEPTH   = 4,
  parameter int ADDR_W        = 32,
  parameter int BYTES_W       = 32,
  parameter int ISSUE_TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_go_i,
  input  logic [NUM_CH*ADDR_W-1:0]  ch_src_i,
  input  logic [NUM_CH*ADDR_W-1:0]  ch_dst_i,
  input  logic [NUM_CH*BYTES_W-1:0] ch_bytes_i,
  output logic [NUM_CH-1:0]         ch_ready_o,
  output logic [NUM_CH-1:0]         ch_done_o,
  output logic [NUM_CH-1:0]         ch_error_o,
  output logic [NUM_CH-1:0]         ch_pending_o,
  output logic                      dma_go_o,
  output logic [ADDR_W-1:0]         dma_src_o,
  output logic [ADDR_W-1:0]         dma_dst_o,
  output logic [BYTES_W-1:0]        dma_bytes_o,
  input  logic                      dma_active_i,
  input  logic                      dma_done_i,
  input  logic                      dma_error_i,
  output logic                      busy_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(ISSUE_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  q_src   [NUM_CH][QUEUE_DEPTH];
  logic [ADDR_W-1:0]  q_dst   [NUM_CH][QUEUE_DEPTH];
  logic [BYTES_W-1:0] q_bytes [NUM_CH][QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr  [NUM_CH];
  logic [PTR_W-1:0]   rd_ptr  [NUM_CH];
  logic [CNT_W-1:0]   count   [NUM_CH];

  logic [NUM_CH-1:0]  q_full, nonempty, zero_len, push, pop, reject, reject_q, owner_oh;
  logic [CH_W-1:0]    rr_ptr, owner, sel, next_rr;
  logic               sel_vld, err, owner_live;
  logic [TMR_W-1:0]   tmr;
  logic [ADDR_W-1:0]  cur_src, cur_dst;
  logic [BYTES_W-1:0] cur_bytes;

  // Per-channel queue status and push/pop/reject decode; zero-length descriptors are never queued.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      q_full[c]   = (count[c] == CNT_W'(QUEUE_DEPTH));
      nonempty[c] = (count[c] != '0);
      zero_len[c] = (ch_bytes_i[c*BYTES_W +: BYTES_W] == '0);
      push[c]     = ch_go_i[c] & ~q_full[c] & ~zero_len[c];
      reject[c]   = ch_go_i[c] & ~q_full[c] & zero_len[c];
      pop[c]      = (state == S_DONE) && (owner == CH_W'(c));
      owner_oh[c] = (owner == CH_W'(c));
    end
  end

  // Round-robin pick: first non-empty channel at or after rr_ptr; scanning backwards lets the nearest win.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = rr_ptr;
    sel_vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (nonempty[idx]) begin
        sel     = CH_W'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  assign next_rr = (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + CH_W'(1);

  // Descriptor storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        q_src[c][wr_ptr[c]]   <= ch_src_i[c*ADDR_W +: ADDR_W];
        q_dst[c][wr_ptr[c]]   <= ch_dst_i[c*ADDR_W +: ADDR_W];
        q_bytes[c][wr_ptr[c]] <= ch_bytes_i[c*BYTES_W +: BYTES_W];
      end
    end
  end

  // Queue pointers and occupancy; a push and the DONE pop on one channel net out in count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      reject_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        count[c] <= count[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
      end
      reject_q <= reject;
    end
  end

  // Scheduler FSM: arbitrate, hold go until the engine goes active (or time out), wait, then retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      err       <= 1'b0;
      tmr       <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      cur_bytes <= '0;
    end else begin
      case (state)
        S_IDLE: if (|nonempty) state <= S_ARB;
        S_ARB: begin
          if (sel_vld) begin
            owner     <= sel;
            cur_src   <= q_src[sel][rd_ptr[sel]];
            cur_dst   <= q_dst[sel][rd_ptr[sel]];
            cur_bytes <= q_bytes[sel][rd_ptr[sel]];
            tmr       <= '0;
            state     <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (dma_active_i) begin
            state <= S_WAIT;
          end else if (tmr == TMR_W'(ISSUE_TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_WAIT: begin
          err <= err | dma_error_i;
          if (dma_done_i || !dma_active_i) state <= S_DONE;
        end
        S_DONE: begin
          rr_ptr <= next_rr;
          err    <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The owner is only meaningful once ARB has latched it, so ARB itself does not mark it pending.
  assign owner_live   = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DONE);
  assign ch_ready_o   = ~q_full;
  assign ch_pending_o = nonempty | (owner_live ? owner_oh : '0);
  assign ch_done_o    = (state == S_DONE && !err) ? owner_oh : '0;
  assign ch_error_o   = reject_q | ((state == S_DONE && err) ? owner_oh : '0);
  assign dma_go_o     = (state == S_ISSUE);
  assign dma_src_o    = dma_go_o ? cur_src : '0;
  assign dma_dst_o    = dma_go_o ? cur_dst : '0;
  assign dma_bytes_o  = dma_go_o ? cur_bytes : '0;
  assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_dma_chan_scheduler.sv
// Bench for dma_chan_scheduler: DMA engine model, issue/completion scoreboard, directed scenarios.
// Model drives engine status 2 ns after each rising edge; checks sample on falling edges.
// All waits are cycle-bounded; an expired bound is reported as a mismatch.
module tb_dma_chan_scheduler;
  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int BW  = 32;

  typedef struct { logic [31:0] src; logic [31:0] dst; logic [31:0] bytes; } iss_t;
  typedef struct { logic [NCH-1:0] done; logic [NCH-1:0] err; } cmp_t;

  logic              clk, rst;
  logic [NCH-1:0]    ch_go_i, ch_ready_o, ch_done_o, ch_error_o, ch_pending_o;
  logic [NCH*AW-1:0] ch_src_i, ch_dst_i;
  logic [NCH*BW-1:0] ch_bytes_i;
  logic              dma_go_o, dma_active_i, dma_done_i, dma_error_i, busy_o;
  logic [AW-1:0]     dma_src_o, dma_dst_o;
  logic [BW-1:0]     dma_bytes_o;

  iss_t issue_q[$];
  cmp_t comp_q[$];
  int   n_cmp = 0, n_mis = 0, n_spur = 0;
  int   last_go_len = 0, last_gap = 0;
  int   m_delay = 0, m_len = 3;
  bit   m_err = 0, m_hang = 0, m_stall = 0;

  dma_chan_scheduler #(.NUM_CH(NCH), .QUEUE_DEPTH(4), .ADDR_W(AW), .BYTES_W(BW), .ISSUE_TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .ch_go_i(ch_go_i), .ch_src_i(ch_src_i), .ch_dst_i(ch_dst_i),
    .ch_bytes_i(ch_bytes_i), .ch_ready_o(ch_ready_o), .ch_done_o(ch_done_o),
    .ch_error_o(ch_error_o), .ch_pending_o(ch_pending_o), .dma_go_o(dma_go_o),
    .dma_src_o(dma_src_o), .dma_dst_o(dma_dst_o), .dma_bytes_o(dma_bytes_o),
    .dma_active_i(dma_active_i), .dma_done_i(dma_done_i), .dma_error_i(dma_error_i),
    .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_desc(input int c, input logic [31:0] s, input logic [31:0] d, input logic [31:0] b);
    ch_go_i[c]           = 1'b1;
    ch_src_i[c*AW +: AW] = s;
    ch_dst_i[c*AW +: AW] = d;
    ch_bytes_i[c*BW +: BW] = b;
  endtask

  task automatic expect_issue(input int c, input logic [31:0] s, input logic [31:0] d,
                              input logic [31:0] b, input bit is_err);
    cmp_t ce;
    issue_q.push_back('{s, d, b});
    ce.done = is_err ? '0 : NCH'(1 << c);
    ce.err  = is_err ? NCH'(1 << c) : '0;
    comp_q.push_back(ce);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((issue_q.size() != 0 || comp_q.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_in_time"}, (n < budget), 1);
    chk({tag, "_sb_empty"}, issue_q.size() + comp_q.size(), 0);
    chk({tag, "_no_spurious"}, n_spur, 0);
  endtask

  task automatic wait_pulse(input bit on_err, input int c, input int budget, output bit hit);
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      hit = on_err ? ch_error_o[c] : ch_done_o[c];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // DMA engine model: go -> (m_delay) -> active for m_len cycles -> done; m_stall freezes, m_hang ignores go.
  initial begin
    int m_cnt, m_dcnt;
    bit m_busy;
    m_cnt = 0; m_dcnt = 0; m_busy = 0;
    dma_active_i = 0; dma_done_i = 0; dma_error_i = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        dma_active_i = 0; dma_done_i = 0; dma_error_i = 0;
        m_busy = 0; m_dcnt = 0;
      end else if (!m_busy) begin
        dma_active_i = 0; dma_done_i = 0; dma_error_i = 0;
        if (dma_go_o && !m_hang) begin
          if (m_dcnt >= m_delay) begin
            m_busy = 1; m_dcnt = 0; m_cnt = m_len; dma_active_i = 1;
          end else begin
            m_dcnt++;
          end
        end
      end else begin
        dma_error_i = 0;
        if (!m_stall) begin
          m_cnt--;
          if (m_err && m_cnt == 2) dma_error_i = 1;
          if (m_cnt == 0) begin
            dma_done_i = 1;
            m_busy = 0;
          end
        end
      end
    end
  end

  // Monitor: compare each new issue and each done/error pulse against the scoreboard.
  initial begin
    iss_t ie;
    cmp_t ce;
    bit   prev_go, gap_arm;
    int   go_run, gap_cnt;
    prev_go = 0; gap_arm = 0; go_run = 0; gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_go = 0; gap_arm = 0; go_run = 0;
      end else begin
        if (dma_done_i) begin
          gap_arm = 1; gap_cnt = 0;
        end else if (gap_arm && !dma_go_o) begin
          gap_cnt++;
        end
        if (dma_go_o && !prev_go) begin
          if (gap_arm) begin
            last_gap = gap_cnt; gap_arm = 0;
          end
          if (issue_q.size() == 0) n_spur++;
          else begin
            ie = issue_q.pop_front();
            chk("issue_src", dma_src_o, ie.src);
            chk("issue_dst", dma_dst_o, ie.dst);
            chk("issue_bytes", dma_bytes_o, ie.bytes);
          end
        end
        if (dma_go_o) go_run++;
        else if (go_run != 0) begin
          last_go_len = go_run; go_run = 0;
        end
        prev_go = dma_go_o;
        if ((ch_done_o | ch_error_o) != '0) begin
          if (comp_q.size() == 0) n_spur++;
          else begin
            ce = comp_q.pop_front();
            chk("pulse_done", ch_done_o, ce.done);
            chk("pulse_err", ch_error_o, ce.err);
          end
        end
      end
    end
  end

  initial begin
    bit hit;
    rst = 1'b1; ch_go_i = '0; ch_src_i = '0; ch_dst_i = '0; ch_bytes_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ch_ready_o, 4'hF);
    chk("rst_busy", busy_o, 0);
    chk("rst_go", dma_go_o, 0);
    chk("rst_pending", ch_pending_o, 0);
    chk("rst_pulses", {ch_done_o, ch_error_o}, 0);
    chk("rst_src", dma_src_o, 0);

    // T1: single descriptor, go two edges after capture, held until active.
    m_delay = 3; m_len = 4;
    expect_issue(0, 32'h1100_0100, 32'h1400_0100, 32'd256, 0);
    set_desc(0, 32'h1100_0100, 32'h1400_0100, 32'd256);
    @(negedge clk); ch_go_i = '0;
    chk("t1_pending", ch_pending_o, 4'b0001);
    chk("t1_idle_go", dma_go_o, 0);
    @(negedge clk);
    chk("t1_arb_busy", busy_o, 1);
    chk("t1_arb_go", dma_go_o, 0);
    @(negedge clk);
    chk("t1_go", dma_go_o, 1);
    chk("t1_src", dma_src_o, 32'h1100_0100);
    chk("t1_bytes", dma_bytes_o, 32'd256);
    drain("t1", 100);
    chk("t1_go_len", last_go_len, 4);
    chk("t1_pending_end", ch_pending_o, 0);

    // T2: round robin over 8 descriptors pushed on all channels in two cycles.
    do_reset();
    m_delay = 0; m_len = 3;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++)
        expect_issue(c, 32'h2000_0000 | (c << 16) | r, 32'h3000_0000 | (c << 16) | r, 32'd64 + r, 0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NCH; c++)
        set_desc(c, 32'h2000_0000 | (c << 16) | r, 32'h3000_0000 | (c << 16) | r, 32'd64 + r);
      @(negedge clk);
    end
    ch_go_i = '0;
    drain("t2", 300);
    chk("t2_gap", last_gap, 3);

    // T3: queue full while the engine stalls; a fifth push is dropped.
    m_stall = 1;
    for (int k = 0; k < 4; k++) expect_issue(1, 32'h4000_0000 + k, 32'h5000_0000 + k, 32'd16, 0);
    for (int k = 0; k < 4; k++) begin
      set_desc(1, 32'h4000_0000 + k, 32'h5000_0000 + k, 32'd16);
      @(negedge clk);
    end
    ch_go_i = '0;
    chk("t3_full", ch_ready_o[1], 0);
    set_desc(1, 32'hDEAD_0000, 32'hDEAD_0001, 32'd8);
    @(negedge clk); ch_go_i = '0;
    chk("t3_still_full", ch_ready_o[1], 0);
    repeat (2) @(negedge clk);
    m_stall = 0;
    wait_pulse(0, 1, 50, hit);
    chk("t3_first_done", hit, 1);
    chk("t3_ready_in_done", ch_ready_o[1], 0);
    @(negedge clk);
    chk("t3_ready_after_done", ch_ready_o[1], 1);
    drain("t3", 200);

    // T4: engine error mid-transfer, then zero-byte rejection.
    m_err = 1; m_len = 4;
    expect_issue(2, 32'h6000_0000, 32'h6100_0000, 32'd32, 1);
    set_desc(2, 32'h6000_0000, 32'h6100_0000, 32'd32);
    @(negedge clk); ch_go_i = '0;
    drain("t4a", 100);
    m_err = 0;
    comp_q.push_back('{4'b0000, 4'b1000});
    set_desc(3, 32'h7000_0000, 32'h7100_0000, 32'd0);
    @(negedge clk); ch_go_i = '0;
    chk("t4_reject_pulse", ch_error_o, 4'b1000);
    repeat (3) @(negedge clk);
    chk("t4_reject_no_go", busy_o, 0);
    chk("t4_reject_pending", ch_pending_o, 0);
    drain("t4b", 20);

    // T5: issue timeout, then the next queued descriptor issues normally.
    m_hang = 1; m_len = 3;
    expect_issue(0, 32'h8000_0000, 32'h8100_0000, 32'd4, 1);
    expect_issue(1, 32'h9000_0000, 32'h9100_0000, 32'd4, 0);
    set_desc(0, 32'h8000_0000, 32'h8100_0000, 32'd4);
    @(negedge clk); ch_go_i = '0;
    set_desc(1, 32'h9000_0000, 32'h9100_0000, 32'd4);
    @(negedge clk); ch_go_i = '0;
    wait_pulse(1, 0, 400, hit);
    chk("t5_timeout_seen", hit, 1);
    m_hang = 0;
    @(negedge clk);
    chk("t5_go_len", last_go_len, 256);
    drain("t5", 100);

    // T6: reset during WAIT with three more descriptors queued.
    m_stall = 1;
    issue_q.push_back('{32'hA000_0000, 32'hA100_0000, 32'd4});
    set_desc(0, 32'hA000_0000, 32'hA100_0000, 32'd4);
    @(negedge clk); ch_go_i = '0;
    hit = 0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      hit = busy_o && !dma_go_o && dma_active_i;
    end
    chk("t6_in_wait", hit, 1);
    for (int c = 1; c < NCH; c++) set_desc(c, 32'hB000_0000 + c, 32'hB100_0000, 32'd4);
    @(negedge clk); ch_go_i = '0;
    chk("t6_pending_all", ch_pending_o, 4'hF);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", ch_ready_o, 4'hF);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_pending", ch_pending_o, 0);
    chk("t6_rst_go", {dma_go_o, dma_src_o, dma_bytes_o}, 0);
    @(negedge clk);
    m_stall = 0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_spurious", n_spur, 0);
    chk("t6_sb_empty", issue_q.size() + comp_q.size(), 0);
    chk("t6_idle", {busy_o, ch_pending_o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
